// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C master sequencer: runs one START/STOP/WRITE/READ command as four
// tick-paced phases, drives open-drain SCL/SDA enables, handles stretching and arbitration.
module i2c_bit_ctrl (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_cmd_valid,
    input  logic [1:0] i_cmd,
    input  logic       i_cmd_bit,
    output logic       o_cmd_ready,
    output logic       o_done,
    output logic       o_rx_bit,
    output logic       o_arb_lost,
    output logic       o_busy,
    input  logic       i_scl_in,
    input  logic       i_sda_in,
    output logic       o_scl_oe,
    output logic       o_sda_oe
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH_A = 3'd1,
        PH_B = 3'd2,
        PH_C = 3'd3,
        PH_D = 3'd4
    } state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    state_t     state;
    logic [1:0] cmd;
    logic       cmd_bit;
    logic       scl_meta;
    logic       scl_sync;
    logic       sda_meta;
    logic       sda_sync;
    logic       advance_c;
    logic       arb_check_c;

    // Line enables {scl_oe, sda_oe} for a command in a given phase (1 = drive low).
    function automatic logic [1:0] line_levels(input logic [1:0] c, input state_t ph, input logic b);
        logic [1:0] lv;
        lv = 2'b00;
        case (c)
            CMD_START: begin
                case (ph)
                    PH_B, PH_C: lv = 2'b01;
                    PH_D:       lv = 2'b11;
                    default:    lv = 2'b00;
                endcase
            end
            CMD_STOP: begin
                case (ph)
                    PH_A:    lv = 2'b11;
                    PH_B:    lv = 2'b01;
                    default: lv = 2'b00;
                endcase
            end
            CMD_WRITE: begin
                case (ph)
                    PH_A, PH_D: lv = {1'b1, ~b};
                    default:    lv = {1'b0, ~b};
                endcase
            end
            default: begin
                case (ph)
                    PH_A, PH_D: lv = 2'b10;
                    default:    lv = 2'b00;
                endcase
            end
        endcase
        return lv;
    endfunction

    // Pad synchronizers; idle bus reads high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            scl_meta <= i_scl_in;
            scl_sync <= scl_meta;
            sda_meta <= i_sda_in;
            sda_sync <= sda_meta;
        end
    end

    // A tick is ignored while we release SCL but a slave still holds it low.
    assign advance_c   = i_tick && (o_scl_oe || scl_sync);
    assign arb_check_c = (cmd == CMD_STOP) || ((cmd == CMD_WRITE) && cmd_bit);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cmd         <= CMD_START;
            cmd_bit     <= 1'b0;
            o_cmd_ready <= 1'b1;
            o_done      <= 1'b0;
            o_rx_bit    <= 1'b0;
            o_arb_lost  <= 1'b0;
            o_busy      <= 1'b0;
            o_scl_oe    <= 1'b0;
            o_sda_oe    <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            o_arb_lost <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        state                  <= PH_A;
                        cmd                    <= i_cmd;
                        cmd_bit                <= i_cmd_bit;
                        {o_scl_oe, o_sda_oe}   <= line_levels(i_cmd, PH_A, i_cmd_bit);
                        o_cmd_ready            <= 1'b0;
                        o_busy                 <= 1'b1;
                    end
                end
                PH_A: begin
                    if (advance_c) begin
                        state                <= PH_B;
                        {o_scl_oe, o_sda_oe} <= line_levels(cmd, PH_B, cmd_bit);
                    end
                end
                PH_B: begin
                    if (advance_c) begin
                        state                <= PH_C;
                        {o_scl_oe, o_sda_oe} <= line_levels(cmd, PH_C, cmd_bit);
                    end
                end
                PH_C: begin
                    if (advance_c) begin
                        // Released SDA read back low: another master owns the bus.
                        if (arb_check_c && !sda_sync) begin
                            state                <= IDLE;
                            {o_scl_oe, o_sda_oe} <= 2'b00;
                            o_arb_lost           <= 1'b1;
                            o_cmd_ready          <= 1'b1;
                            o_busy               <= 1'b0;
                        end else begin
                            state                <= PH_D;
                            {o_scl_oe, o_sda_oe} <= line_levels(cmd, PH_D, cmd_bit);
                            if (cmd == CMD_READ) begin
                                o_rx_bit <= sda_sync;
                            end
                        end
                    end
                end
                PH_D: begin
                    if (advance_c) begin
                        state       <= IDLE;
                        o_done      <= 1'b1;
                        o_cmd_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Bench for i2c_bit_ctrl: directed commands on an open-drain pad model with a
// completion scoreboard popped by an independent monitor.
module tb_i2c_bit_ctrl;

    localparam logic [1:0] C_START = 2'b00;
    localparam logic [1:0] C_STOP  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] C_READ  = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_bit;
    logic       cmd_ready;
    logic       done;
    logic       rx_bit;
    logic       arb_lost;
    logic       busy;
    logic       scl_in;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_force_low;
    logic       sda_force_low;

    typedef struct {
        logic arb;
        logic chk_rx;
        logic rx;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   arb_seen = 0;
    int   exp_done = 0;
    int   exp_arb = 0;
    int   busy_ticks = 0;
    int   tcnt = 0;

    int   r_cycles, r_scl_rel, r_sda_wrong, r_ticks;
    logic r_rise_seen, r_rise_scl, r_fall_seen, r_fall_scl, r_cap_seen, r_cap_bit;

    i2c_bit_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_tick      (tick),
        .i_cmd_valid (cmd_valid),
        .i_cmd       (cmd),
        .i_cmd_bit   (cmd_bit),
        .o_cmd_ready (cmd_ready),
        .o_done      (done),
        .o_rx_bit    (rx_bit),
        .o_arb_lost  (arb_lost),
        .o_busy      (busy),
        .i_scl_in    (scl_in),
        .i_sda_in    (sda_in),
        .o_scl_oe    (scl_oe),
        .o_sda_oe    (sda_oe)
    );

    // Open-drain bus with pull-ups; the bench can hold either line low.
    assign scl_in = ~scl_oe & ~scl_force_low;
    assign sda_in = ~sda_oe & ~sda_force_low;

    initial forever #5 clk = ~clk;

    // Free-running quarter-bit tick, one cycle in four.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = (tcnt == 3);
            tcnt = (tcnt + 1) % 4;
        end
    end

    always @(posedge clk) begin
        if (busy && tick) busy_ticks++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (done || arb_lost)) begin
            if (done) done_seen++;
            if (arb_lost) arb_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got done=%0b arb=%0b expected none", done, arb_lost);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_vs_arb", {30'd0, done, arb_lost}, e.arb ? 32'd1 : 32'd2);
                if (e.chk_rx) chk("rx_bit", rx_bit, e.rx);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_scl_oe"}, scl_oe, 0);
        chk({tag, "_sda_oe"}, sda_oe, 0);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rx_bit"}, rx_bit, 0);
        chk({tag, "_arb_lost"}, arb_lost, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Issue one command, then observe line activity until it completes.
    task automatic run_cmd(input logic [1:0] c, input logic b, input logic exp_arb_i,
                           input logic chk_rx, input logic exp_rx);
        logic prev_sda, prev_scl, finished;
        int   t0;
        exp_t e;
        e.arb = exp_arb_i;
        e.chk_rx = chk_rx;
        e.rx = exp_rx;
        sb_q.push_back(e);
        if (exp_arb_i) exp_arb++; else exp_done++;
        @(negedge clk);
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd = c;
        cmd_bit = b;
        prev_sda = sda_oe;
        prev_scl = scl_oe;
        t0 = busy_ticks;
        @(negedge clk);
        cmd_valid = 1'b0;
        r_cycles = 0; r_scl_rel = 0; r_sda_wrong = 0;
        r_rise_seen = 0; r_rise_scl = 1; r_fall_seen = 0; r_fall_scl = 1;
        r_cap_seen = 0; r_cap_bit = 0;
        finished = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r_cycles++;
            if (sda_oe && !prev_sda) begin r_rise_seen = 1; r_rise_scl = scl_oe | prev_scl; end
            if (!sda_oe && prev_sda) begin r_fall_seen = 1; r_fall_scl = scl_oe | prev_scl; end
            if (!scl_oe && prev_scl) begin r_cap_seen = 1; r_cap_bit = ~sda_oe; end
            if (busy && !scl_oe) r_scl_rel++;
            if (c == C_WRITE && busy && (sda_oe != ~b)) r_sda_wrong++;
            if (done || arb_lost) begin
                finished = 1'b1;
                break;
            end
            prev_sda = sda_oe;
            prev_scl = scl_oe;
            @(negedge clk);
        end
        r_ticks = busy_ticks - t0;
        chk("cmd_completes", finished, 1);
    endtask

    initial begin
        logic [7:0] byte_v;
        logic       found;
        int         low_hold;
        int         d0;

        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd = 2'b00;
        cmd_bit = 1'b0;
        scl_force_low = 1'b0;
        sda_force_low = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // START then STOP
        run_cmd(C_START, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_ticks", r_ticks, 4);
        chk("start_sda_fell_scl_high", {r_rise_seen, r_rise_scl}, 2'b10);
        chk("start_idle_scl_oe", scl_oe, 1);
        chk("start_idle_sda_oe", sda_oe, 1);
        run_cmd(C_STOP, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stop_ticks", r_ticks, 4);
        chk("stop_sda_rose_scl_high", {r_fall_seen, r_fall_scl}, 2'b10);
        chk("stop_idle_scl_oe", scl_oe, 0);
        chk("stop_idle_sda_oe", sda_oe, 0);

        // START + byte 0xA5, MSB first
        run_cmd(C_START, 1'b0, 1'b0, 1'b0, 1'b0);
        byte_v = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            run_cmd(C_WRITE, byte_v[i], 1'b0, 1'b0, 1'b0);
            chk("write_bit_at_scl_rise", {r_cap_seen, r_cap_bit}, {1'b1, byte_v[i]});
            chk("write_sda_steady", r_sda_wrong, 0);
            if (i == 7) begin
                chk("write_ticks", r_ticks, 4);
                chk("write_scl_high_cycles", r_scl_rel, 8);
            end
        end

        // READ with SDA held low, then released
        sda_force_low = 1'b1;
        run_cmd(C_READ, 1'b0, 1'b0, 1'b1, 1'b0);
        sda_force_low = 1'b0;
        run_cmd(C_READ, 1'b0, 1'b0, 1'b1, 1'b1);
        run_cmd(C_WRITE, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rx_bit_held_after_write", rx_bit, 1);

        // Clock stretch: slave holds SCL low for 20 cycles at the start of PH_B
        d0 = done_seen;
        low_hold = 0;
        fork
            run_cmd(C_WRITE, 1'b1, 1'b0, 1'b0, 1'b0);
            begin
                found = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (busy && !scl_oe) begin
                        found = 1'b1;
                        break;
                    end
                end
                chk("stretch_reached_ph_b", found, 1);
                scl_force_low = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (busy && !scl_oe) low_hold++;
                end
                scl_force_low = 1'b0;
            end
        join
        chk("stretch_no_advance", low_hold, 20);
        chk("stretch_window_ge_28", (r_scl_rel >= 28) ? 1 : 0, 1);
        chk("stretch_one_done", done_seen - d0, 1);
        chk("stretch_bit", {r_cap_seen, r_cap_bit}, 2'b11);

        // Arbitration loss on WRITE 1 with SDA held low
        sda_force_low = 1'b1;
        run_cmd(C_WRITE, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("arb_ticks", r_ticks, 3);
        chk("arb_scl_oe", scl_oe, 0);
        chk("arb_sda_oe", sda_oe, 0);
        chk("arb_ready", cmd_ready, 1);
        chk("arb_busy", busy, 0);
        @(negedge clk);
        chk("arb_pulse_width", arb_lost, 0);
        sda_force_low = 1'b0;

        // Reset in the middle of a READ
        cmd_valid = 1'b1;
        cmd = C_READ;
        cmd_bit = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy && !scl_oe) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("read_reached_ph_b", found, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_cmd(C_START, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_reset_start_ticks", r_ticks, 4);
        chk("post_reset_idle_scl_oe", scl_oe, 1);
        chk("post_reset_idle_sda_oe", sda_oe, 1);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        chk("done_count", done_seen, exp_done);
        chk("arb_count", arb_seen, exp_arb);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
